mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage. Consumes the 106-bit EX_MEM register produced by the execute stage.
- Performs data-RAM and memory-mapped peripheral access: timer, LEDs, switches and 7-segment display.
- Drives the MEM-stage forwarding signals back to execute and registers the MEM_WB word for write-back.

Parameters:
- RAM_WORDS, 256: data RAM depth in 32-bit words; must be a power of two.
- RAM_AW, 8: RAM word-address width; must equal log2(RAM_WORDS).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous reset, active-high
- EX_MEM  input  106  [31:0] store data; [63:32] ALU result/address; [68:64] write register; [70:69] {MemWrite,MemRead}; [73:71] {MemtoReg[1:0],RegWrite}; [105:74] PC_plus4
- switch  input  8  external switch levels
- MEM_RegWrite  output  1  EX_MEM[71], forwarding qualifier
- MEM_WriteRegister  output  5  EX_MEM[68:64]
- MEM_RegWriteData  output  32  write-back data selected this cycle (combinational)
- MEM_WB  output  38  [31:0] RegWriteData; [36:32] WriteRegister; [37] RegWrite
- led  output  8  LED register
- digi  output  12  7-segment register
- irq  output  1  timer interrupt request (= TCON[2])

Behaviour:
- Address: addr = EX_MEM[63:32]. Bits [1:0] are ignored; all accesses are word accesses.
- Address map:
  - 0x0000_0000..RAM_WORDS*4-1: RAM, word index addr[RAM_AW+1:2]
  - 0x4000_0000: TH, r/w
  - 0x4000_0004: TL, r/w
  - 0x4000_0008: TCON[2:0], r/w, upper bits read 0
  - 0x4000_000C: led[7:0], r/w
  - 0x4000_0010: switch, read-only, zero-extended
  - 0x4000_0014: digi[11:0], r/w
  - Any other address: reads return 0; writes are ignored with no side effect.
- RAM read: asynchronous (combinational), so load data is available in the same cycle for MEM forwarding. Read data is 0 when MemRead = 0.
- RAM write: synchronous at the clk edge when MemWrite = 1 and the address is in RAM range. Data = EX_MEM[31:0].
- RAM is not cleared by rst. Contents are retained across reset.
- MemRead and MemWrite both set: the write is performed and the read returns the old value.
- MemtoReg selection for MEM_RegWriteData:
  - 00: ALU result
  - 01: memory/peripheral read data
  - 10: PC_plus4 (jal/link)
  - 11: ALU result
- MEM_WB: registered each cycle from {EX_MEM[71], EX_MEM[68:64], MEM_RegWriteData}. Latency is 1 cycle.
- Timer, TCON bits: [0] run, [1] interrupt enable, [2] interrupt status.
  - Each cycle with run = 1: TL <= TL + 1.
  - When TL == 0xFFFF_FFFF and run = 1: TL <= TH, and if enable = 1, status <= 1.
  - Status is sticky; it is cleared only by a software write of 0 to TCON[2].
- Timer collisions: a software write to TL or TCON in the same cycle as an increment or overflow wins outright. The increment/reload is discarded and the status set is discarded.
- Peripheral reads return the pre-edge register value.
- Reset (asynchronous, any time including mid-access): MEM_WB=0, TH=0, TL=0, TCON=0, led=0, digi=0, irq=0. A store in flight at reset assertion is dropped.
- MEM_RegWrite, MEM_WriteRegister and MEM_RegWriteData follow EX_MEM combinationally. Since EX_MEM resets to 0, they are 0 during reset.

Decomposition:
- Shared package (mem_pkg):
  - peripheral address constants
  - MemtoReg encodings (MTR_ALU, MTR_MEM, MTR_PC4)
  - EX_MEM and MEM_WB field offsets, also used by the execute and write-back stages
  - TCON bit indices
- One sub-module: mem_timer, holding TH/TL/TCON with a write port (we, sel, wdata) and irq output.
- RAM array and the remaining peripherals stay in mem_stage.

Test Plan:
- Store 0xDEADBEEF to 0x0000_0010, then load the same address with MemtoReg=01, RegWrite=1, reg 8 → load cycle: MEM_RegWriteData = 0xDEADBEEF combinationally; next edge: MEM_WB = {1,5'd8,0xDEADBEEF}.
- jal pass-through: MemtoReg=10, PC_plus4=0x0000_0044, reg 31 → MEM_WB[31:0] = 0x44, MEM_WB[36:32] = 31; no memory access.
- Timer: write TH=0xFFFF_FFF0, TL=0xFFFF_FFFE, TCON=3 → TL reaches 0xFFFF_FFFF, then reloads 0xFFFF_FFF0; irq rises on the reload edge. Write TCON=3 → irq = 0 next cycle.
- Collision: write TL=0x5 in the overflow cycle → TL = 0x5; no reload; irq stays 0.
- Peripherals: switch=0xA5, load 0x4000_0010 → data 0x0000_00A5. Store 0x1FF to 0x4000_000C → led = 0xFF. Load 0x5000_0000 → 0. Store to 0x5000_0000 → no state change.
- Async reset mid-run (timer running, led=0x3C, MEM_WB valid) → all outputs 0 immediately. A previously stored RAM word still reads back after reset release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage and its neighbours: address map,
// MemtoReg encodings, pipeline-register field offsets and timer control bits.
package mem_pkg;

  // Memory-mapped peripheral word addresses
  localparam logic [31:0] ADDR_TH   = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL   = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED  = 32'h4000_000C;
  localparam logic [31:0] ADDR_SW   = 32'h4000_0010;
  localparam logic [31:0] ADDR_DIGI = 32'h4000_0014;

  // MemtoReg encodings (2'b11 also selects the ALU result)
  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  // EX_MEM field offsets
  localparam int EXM_W        = 106;
  localparam int EXM_DATA_LSB = 0;
  localparam int EXM_ADDR_LSB = 32;
  localparam int EXM_WREG_LSB = 64;
  localparam int EXM_MEMREAD  = 69;
  localparam int EXM_MEMWRITE = 70;
  localparam int EXM_REGWRITE = 71;
  localparam int EXM_MTR_LSB  = 72;
  localparam int EXM_PC4_LSB  = 74;

  // MEM_WB field offsets
  localparam int MWB_W        = 38;
  localparam int MWB_DATA_LSB = 0;
  localparam int MWB_WREG_LSB = 32;
  localparam int MWB_REGWRITE = 37;

  // TCON bit indices
  localparam int TCON_RUN = 0;
  localparam int TCON_IE  = 1;
  localparam int TCON_IS  = 2;

  // Timer register select
  typedef enum logic [1:0] {
    TSEL_TH   = 2'd0,
    TSEL_TL   = 2'd1,
    TSEL_TCON = 2'd2,
    TSEL_NONE = 2'd3
  } tsel_e;

  // All accesses are word accesses: drop the byte offset
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_timer.sv
// Reloading 32-bit timer: TL counts up while running, reloads from TH on
// overflow and latches a sticky interrupt status when enabled.
module mem_timer
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  tsel_e       sel_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic [2:0]  tcon_o,
  output logic        irq_o
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;

  // Next state: count/reload first, then a software write overrides it
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (tcon_q[TCON_RUN]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        if (tcon_q[TCON_IE]) begin
          tcon_d[TCON_IS] = 1'b1;
        end else begin
          tcon_d[TCON_IS] = tcon_q[TCON_IS];
        end
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end else begin
      tl_d = tl_q;
    end
    if (we_i) begin
      case (sel_i)
        TSEL_TH:   th_d = wdata_i;
        TSEL_TL: begin
          tl_d   = wdata_i;
          tcon_d = tcon_q;
        end
        TSEL_TCON: begin
          tl_d   = tl_q;
          tcon_d = wdata_i[2:0];
        end
        default: begin
          th_d = th_d;
        end
      endcase
    end else begin
      th_d = th_d;
    end
  end

  // Timer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      th_q   <= 32'd0;
      tl_q   <= 32'd0;
      tcon_q <= 3'd0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;
  assign irq_o  = tcon_q[TCON_IS];

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data RAM, memory-mapped peripherals,
// MEM-stage forwarding outputs and the MEM_WB pipeline register.
module mem_stage
  import mem_pkg::*;
#(
  parameter int RAM_WORDS = 256,
  parameter int RAM_AW    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [105:0] EX_MEM,
  input  logic [7:0]   switch,
  output logic         MEM_RegWrite,
  output logic [4:0]   MEM_WriteRegister,
  output logic [31:0]  MEM_RegWriteData,
  output logic [37:0]  MEM_WB,
  output logic [7:0]   led,
  output logic [11:0]  digi,
  output logic         irq
);

  logic [31:0] store_data_s, addr_s, addr_w_s, pc4_s, rdata_s;
  logic [1:0]  mtr_s;
  logic        mem_read_s, mem_write_s, in_ram_s, ram_we_s, timer_we_s;
  logic [RAM_AW-1:0] ram_idx_s;
  tsel_e       timer_sel_s;
  logic [31:0] th_s, tl_s;
  logic [2:0]  tcon_s;
  logic [31:0] ram_q [RAM_WORDS];
  logic [7:0]  led_q;
  logic [11:0] digi_q;
  logic [37:0] mem_wb_q, mem_wb_d;
  logic        unused_s;

  assign store_data_s = EX_MEM[EXM_DATA_LSB +: 32];
  assign addr_s       = EX_MEM[EXM_ADDR_LSB +: 32];
  assign pc4_s        = EX_MEM[EXM_PC4_LSB +: 32];
  assign mtr_s        = EX_MEM[EXM_MTR_LSB +: 2];
  assign mem_read_s   = EX_MEM[EXM_MEMREAD];
  assign mem_write_s  = EX_MEM[EXM_MEMWRITE];
  assign addr_w_s     = word_align(addr_s);
  assign unused_s     = ^addr_s[1:0];

  assign in_ram_s  = (addr_s[31:RAM_AW+2] == {(30-RAM_AW){1'b0}});
  assign ram_idx_s = addr_s[RAM_AW+1:2];
  assign ram_we_s  = mem_write_s & in_ram_s;

  assign MEM_RegWrite      = EX_MEM[EXM_REGWRITE];
  assign MEM_WriteRegister = EX_MEM[EXM_WREG_LSB +: 5];

  // Decode timer register writes
  always_comb begin
    timer_sel_s = TSEL_NONE;
    case (addr_w_s)
      ADDR_TH:   timer_sel_s = TSEL_TH;
      ADDR_TL:   timer_sel_s = TSEL_TL;
      ADDR_TCON: timer_sel_s = TSEL_TCON;
      default:   timer_sel_s = TSEL_NONE;
    endcase
    timer_we_s = mem_write_s & (timer_sel_s != TSEL_NONE);
  end

  mem_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .we_i    (timer_we_s),
    .sel_i   (timer_sel_s),
    .wdata_i (store_data_s),
    .th_o    (th_s),
    .tl_o    (tl_s),
    .tcon_o  (tcon_s),
    .irq_o   (irq)
  );

  // RAM write port; contents survive reset, but a store under reset is dropped
  always_ff @(posedge clk) begin
    if (ram_we_s && !rst) begin
      ram_q[ram_idx_s] <= store_data_s;
    end
  end

  // Asynchronous read of RAM and pre-edge peripheral values
  always_comb begin
    rdata_s = 32'd0;
    if (mem_read_s) begin
      if (in_ram_s) begin
        rdata_s = ram_q[ram_idx_s];
      end else begin
        case (addr_w_s)
          ADDR_TH:   rdata_s = th_s;
          ADDR_TL:   rdata_s = tl_s;
          ADDR_TCON: rdata_s = {29'd0, tcon_s};
          ADDR_LED:  rdata_s = {24'd0, led_q};
          ADDR_SW:   rdata_s = {24'd0, switch};
          ADDR_DIGI: rdata_s = {20'd0, digi_q};
          default:   rdata_s = 32'd0;
        endcase
      end
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Write-back data select and next MEM_WB word
  always_comb begin
    case (mtr_s)
      MTR_MEM: MEM_RegWriteData = rdata_s;
      MTR_PC4: MEM_RegWriteData = pc4_s;
      default: MEM_RegWriteData = addr_s;
    endcase
    mem_wb_d = {EX_MEM[EXM_REGWRITE], EX_MEM[EXM_WREG_LSB +: 5], MEM_RegWriteData};
  end

  // LED / 7-segment registers and the MEM_WB pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q    <= 8'd0;
      digi_q   <= 12'd0;
      mem_wb_q <= 38'd0;
    end else begin
      mem_wb_q <= mem_wb_d;
      if (mem_write_s && addr_w_s == ADDR_LED) begin
        led_q <= store_data_s[7:0];
      end
      if (mem_write_s && addr_w_s == ADDR_DIGI) begin
        digi_q <= store_data_s[11:0];
      end
    end
  end

  assign led    = led_q;
  assign digi   = digi_q;
  assign MEM_WB = mem_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed test of mem_stage: RAM, write-back select, peripherals, timer and reset.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [105:0] EX_MEM;
  logic [7:0]   switch;
  logic         MEM_RegWrite;
  logic [4:0]   MEM_WriteRegister;
  logic [31:0]  MEM_RegWriteData;
  logic [37:0]  MEM_WB;
  logic [7:0]   led;
  logic [11:0]  digi;
  logic         irq;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage dut (
    .clk               (clk),
    .rst               (rst),
    .EX_MEM            (EX_MEM),
    .switch            (switch),
    .MEM_RegWrite      (MEM_RegWrite),
    .MEM_WriteRegister (MEM_WriteRegister),
    .MEM_RegWriteData  (MEM_RegWriteData),
    .MEM_WB            (MEM_WB),
    .led               (led),
    .digi              (digi),
    .irq               (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {pc4, MemtoReg, RegWrite, MemWrite, MemRead, wreg, addr, data}
  function automatic logic [105:0] ex(input logic [31:0] pc4, input logic [1:0] mtr,
                                      input logic rw, input logic mw, input logic mr,
                                      input logic [4:0] wreg, input logic [31:0] addr,
                                      input logic [31:0] data);
    return {pc4, mtr, rw, mw, mr, wreg, addr, data};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [105:0] v);
    EX_MEM = v;
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    drive(ex(32'd0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0, addr, data));
    cyc();
  endtask

  // Drive a load and leave it on the bus; returns combinational read data
  task automatic load(input logic [31:0] addr, output logic [31:0] d);
    drive(ex(32'd0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd1, addr, 32'd0));
    d = MEM_RegWriteData;
  endtask

  logic [31:0] rd;

  initial begin
    rst    = 1'b1;
    EX_MEM = 106'd0;
    switch = 8'h00;
    #12;
    check_eq("rst_mem_wb", {26'd0, MEM_WB}, 64'd0);
    check_eq("rst_led", {56'd0, led}, 64'd0);
    check_eq("rst_digi", {52'd0, digi}, 64'd0);
    check_eq("rst_irq", {63'd0, irq}, 64'd0);
    check_eq("rst_wdata", {32'd0, MEM_RegWriteData}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Store then load back, with forwarding and MEM_WB
    store(32'h0000_0010, 32'hDEAD_BEEF);
    drive(ex(32'd0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd8, 32'h0000_0010, 32'd0));
    check_eq("load_fwd", {32'd0, MEM_RegWriteData}, 64'hDEAD_BEEF);
    check_eq("load_rw", {63'd0, MEM_RegWrite}, 64'd1);
    check_eq("load_wreg", {59'd0, MEM_WriteRegister}, 64'd8);
    cyc();
    check_eq("load_memwb", {26'd0, MEM_WB}, {26'd0, 1'b1, 5'd8, 32'hDEAD_BEEF});

    // jal link
    drive(ex(32'h0000_0044, 2'b10, 1'b1, 1'b0, 1'b0, 5'd31, 32'h0000_0010, 32'd0));
    cyc();
    check_eq("jal_data", {32'd0, MEM_WB[31:0]}, 64'h44);
    check_eq("jal_wreg", {59'd0, MEM_WB[36:32]}, 64'd31);

    // MemtoReg=11 selects ALU result; MemRead=0 yields zero read data
    drive(ex(32'd0, 2'b11, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_1234, 32'd0));
    check_eq("mtr11_alu", {32'd0, MEM_RegWriteData}, 64'h1234);
    drive(ex(32'd0, 2'b01, 1'b1, 1'b0, 1'b0, 5'd2, 32'h0000_0010, 32'd0));
    check_eq("noread_zero", {32'd0, MEM_RegWriteData}, 64'd0);

    // Read and write together: old value read, new value stored
    drive(ex(32'd0, 2'b01, 1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_0010, 32'hCAFE_F00D));
    check_eq("rw_old", {32'd0, MEM_RegWriteData}, 64'hDEAD_BEEF);
    cyc();
    load(32'h0000_0013, rd);
    check_eq("rw_new_unaligned", {32'd0, rd}, 64'hCAFE_F00D);

    // RAM upper boundary and out-of-range alias
    store(32'h0000_03FC, 32'h0BAD_CAFE);
    load(32'h0000_03FC, rd);
    check_eq("ram_last", {32'd0, rd}, 64'h0BAD_CAFE);
    store(32'h0000_0000, 32'h1111_1111);
    load(32'h0000_0400, rd);
    check_eq("ram_oob", {32'd0, rd}, 64'd0);

    // Peripherals
    switch = 8'hA5;
    load(32'h4000_0010, rd);
    check_eq("switch", {32'd0, rd}, 64'hA5);
    store(32'h4000_000C, 32'h0000_01FF);
    check_eq("led_ff", {56'd0, led}, 64'hFF);
    store(32'h4000_0014, 32'hFFFF_F123);
    check_eq("digi", {52'd0, digi}, 64'h123);
    load(32'h4000_000C, rd);
    check_eq("led_read", {32'd0, rd}, 64'hFF);

    // Unmapped accesses
    store(32'h5000_0000, 32'h2222_2222);
    check_eq("unmap_led", {56'd0, led}, 64'hFF);
    check_eq("unmap_digi", {52'd0, digi}, 64'h123);
    load(32'h0000_0000, rd);
    check_eq("unmap_ram0", {32'd0, rd}, 64'h1111_1111);
    load(32'h5000_0000, rd);
    check_eq("unmap_read", {32'd0, rd}, 64'd0);

    // Timer overflow and reload
    store(32'h4000_0000, 32'hFFFF_FFF0);
    store(32'h4000_0004, 32'hFFFF_FFFE);
    store(32'h4000_0008, 32'h0000_0003);
    load(32'h4000_0004, rd);
    check_eq("tl_fffe", {32'd0, rd}, 64'hFFFF_FFFE);
    cyc();
    check_eq("tl_ffff", {32'd0, MEM_RegWriteData}, 64'hFFFF_FFFF);
    check_eq("irq_pre", {63'd0, irq}, 64'd0);
    cyc();
    check_eq("tl_reload", {32'd0, MEM_RegWriteData}, 64'hFFFF_FFF0);
    check_eq("irq_set", {63'd0, irq}, 64'd1);
    load(32'h4000_0008, rd);
    check_eq("tcon_read", {32'd0, rd}, 64'h7);
    store(32'h4000_0008, 32'h0000_0003);
    check_eq("irq_clr", {63'd0, irq}, 64'd0);

    // Software TL write collides with overflow
    store(32'h4000_0004, 32'hFFFF_FFFE);
    load(32'h4000_0004, rd);
    check_eq("col_tl_fffe", {32'd0, rd}, 64'hFFFF_FFFE);
    cyc();
    check_eq("col_tl_ffff", {32'd0, MEM_RegWriteData}, 64'hFFFF_FFFF);
    store(32'h4000_0004, 32'h0000_0005);
    load(32'h4000_0004, rd);
    check_eq("col_tl_5", {32'd0, rd}, 64'h5);
    check_eq("col_irq", {63'd0, irq}, 64'd0);
    cyc();
    check_eq("col_irq_next", {63'd0, irq}, 64'd0);

    // Build up state, then reset asynchronously mid-cycle
    store(32'h4000_000C, 32'h0000_003C);
    store(32'h0000_0020, 32'hAAAA_AAAA);
    store(32'h4000_0004, 32'hFFFF_FFFF);
    drive(ex(32'd0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd9, 32'h0000_0077, 32'd0));
    cyc();
    check_eq("pre_rst_memwb", {26'd0, MEM_WB}, {26'd0, 1'b1, 5'd9, 32'h77});
    check_eq("pre_rst_led", {56'd0, led}, 64'h3C);
    check_eq("pre_rst_irq", {63'd0, irq}, 64'd1);
    drive(ex(32'd0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0020, 32'h1234_5678));
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_memwb", {26'd0, MEM_WB}, 64'd0);
    check_eq("arst_led", {56'd0, led}, 64'd0);
    check_eq("arst_digi", {52'd0, digi}, 64'd0);
    check_eq("arst_irq", {63'd0, irq}, 64'd0);
    cyc();
    EX_MEM = 106'd0;
    #1;
    check_eq("arst_wdata", {32'd0, MEM_RegWriteData}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    load(32'h0000_0020, rd);
    check_eq("ram_keep_drop", {32'd0, rd}, 64'hAAAA_AAAA);
    load(32'h0000_0010, rd);
    check_eq("ram_keep", {32'd0, rd}, 64'hCAFE_F00D);
    load(32'h4000_0004, rd);
    check_eq("tl_after_rst", {32'd0, rd}, 64'd0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
